// File: rtl/serial_period_meter.sv
// ---------------------------------------------------------------------------
// serial_period_meter
//
// Measures the period and high time, in clock cycles, of a serial bitstream
// between consecutive rising edges. Each completed measurement is presented
// with a one-cycle strobe, and a lock flag rises once the waveform has
// repeated itself for LOCK_COUNT consecutive measurements.
//
// Parameters:
//   CNT_WIDTH   width of the period/high counters and outputs (default 8)
//   LOCK_COUNT  consecutive matching measurements needed for lock (1..15)
//
// Ports:
//   clock         in   single clock, shared with the shift register
//   reset_n       in   asynchronous active-low reset
//   clear         in   synchronous clear, same effect as reset
//   sample_in     in   serial input (shift register output)
//   period_out    out  last measured period in cycles
//   high_out      out  last measured high time in cycles
//   period_valid  out  one-cycle strobe when new period/high are presented
//   overflow      out  one-cycle strobe when the period counter saturates
//   locked        out  waveform stable for LOCK_COUNT consecutive matches
//
// Build option:
//   SERIAL_PERIOD_METER_DUTY_EN  when defined, the high-time counter is built,
//   high_out reports the high time and lock compares period and high time.
//   When undefined, high_out is tied to 0 and lock compares period only.
// ---------------------------------------------------------------------------
module serial_period_meter #(
   parameter int CNT_WIDTH  = 8,
   parameter int LOCK_COUNT = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 sample_in,
   output logic [CNT_WIDTH-1:0] period_out,
   output logic [CNT_WIDTH-1:0] high_out,
   output logic                 period_valid,
   output logic                 overflow,
   output logic                 locked
);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MEASURE = 1'b1;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [3:0]           LOCK_TARGET = 4'(LOCK_COUNT);

   logic [0:0]           state_reg;
   logic                 prev_reg;
   logic [CNT_WIDTH-1:0] cnt_reg;
   logic                 ovf_flag_reg;
   logic [3:0]           match_reg;
   logic                 have_ref_reg;
   logic [CNT_WIDTH-1:0] ref_period_reg;
   logic                 rise;
   logic                 same;

   assign rise   = sample_in & ~prev_reg;
   assign locked = (match_reg >= LOCK_TARGET);

`ifdef SERIAL_PERIOD_METER_DUTY_EN
   logic [CNT_WIDTH-1:0] hcnt_reg;
   logic [CNT_WIDTH-1:0] ref_high_reg;
   logic [CNT_WIDTH-1:0] high_reg;

   assign high_out = high_reg;
   assign same     = (cnt_reg == ref_period_reg) && (hcnt_reg == ref_high_reg);

   // High-time counter and its reference. It restarts at 1 on every edge
   // because the edge cycle itself is a high cycle of the new period.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hcnt_reg     <= '0;
         ref_high_reg <= '0;
         high_reg     <= '0;
      end else if (clear) begin
         hcnt_reg     <= '0;
         ref_high_reg <= '0;
         high_reg     <= '0;
      end else if (rise) begin
         if (state_reg == ST_MEASURE && !ovf_flag_reg) begin
            high_reg     <= hcnt_reg;
            ref_high_reg <= hcnt_reg;
         end
         hcnt_reg <= CNT_ONE;
      end else if (state_reg == ST_MEASURE && sample_in && hcnt_reg != CNT_MAX) begin
         hcnt_reg <= hcnt_reg + CNT_ONE;
      end
   end
`else
   assign high_out = '0;
   assign same     = (cnt_reg == ref_period_reg);
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         prev_reg       <= 1'b1;
         cnt_reg        <= '0;
         ovf_flag_reg   <= 1'b0;
         match_reg      <= '0;
         have_ref_reg   <= 1'b0;
         ref_period_reg <= '0;
         period_out     <= '0;
         period_valid   <= 1'b0;
         overflow       <= 1'b0;
      end else if (clear) begin
         // prev returns to 1 so an edge coinciding with clear is lost.
         state_reg      <= ST_IDLE;
         prev_reg       <= 1'b1;
         cnt_reg        <= '0;
         ovf_flag_reg   <= 1'b0;
         match_reg      <= '0;
         have_ref_reg   <= 1'b0;
         ref_period_reg <= '0;
         period_out     <= '0;
         period_valid   <= 1'b0;
         overflow       <= 1'b0;
      end else begin
         prev_reg     <= sample_in;
         period_valid <= 1'b0;
         overflow     <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (rise) begin
                  state_reg    <= ST_MEASURE;
                  cnt_reg      <= CNT_ONE;
                  ovf_flag_reg <= 1'b0;
               end
            end
            ST_MEASURE: begin
               if (rise) begin
                  // An edge while the counter sits at its maximum still
                  // reports: the period is exactly CNT_MAX cycles.
                  if (!ovf_flag_reg) begin
                     period_out     <= cnt_reg;
                     period_valid   <= 1'b1;
                     ref_period_reg <= cnt_reg;
                     if (!have_ref_reg) begin
                        have_ref_reg <= 1'b1;
                        match_reg    <= '0;
                     end else if (same) begin
                        if (match_reg < LOCK_TARGET)
                           match_reg <= match_reg + 4'd1;
                     end else begin
                        match_reg <= '0;
                     end
                  end
                  cnt_reg      <= CNT_ONE;
                  ovf_flag_reg <= 1'b0;
               end else if (cnt_reg == CNT_MAX) begin
                  // Counter already saturated and the period keeps going:
                  // this measurement can no longer be represented.
                  if (!ovf_flag_reg) begin
                     overflow     <= 1'b1;
                     ovf_flag_reg <= 1'b1;
                     match_reg    <= '0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
